// File: rtl/bg_rom_reader.sv
// Background ROM pixel fetch: VGA timing in, ROM address out, timing + RGB out
// three clocks later, with a per-frame horizontal scroll offset that wraps.
module bg_rom_reader #(
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] hcount_in,
  input  logic [10:0] vcount_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        hblnk_in,
  input  logic        vblnk_in,
  input  logic        scroll_en,
  input  logic [3:0]  scroll_step,
  output logic [19:0] rom_addr,
  input  logic [11:0] rom_rgb,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [11:0] rgb_out,
  output logic [9:0]  x_off
);

  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] V_LIM = 11'(V_ACTIVE);

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        hb;
    logic        vb;
  } tim_t;

  tim_t        tim_in;
  tim_t        tim_s1_q, tim_s2_q, tim_s3_q;
  logic [1:0]  vld_pipe_q;
  logic [19:0] rom_addr_q, rom_addr_d;
  logic [11:0] rgb_q, rgb_d;
  logic [9:0]  x_off_q, x_off_d;
  logic [9:0]  col;
  logic        vis;
  logic        frame_evt;

  assign tim_in = '{h: hcount_in, v: vcount_in, hs: hsync_in, vs: vsync_in,
                    hb: hblnk_in, vb: vblnk_in};

  assign vis       = !hblnk_in && !vblnk_in && (hcount_in < H_LIM) && (vcount_in < V_LIM);
  assign frame_evt = (vcount_in == V_LIM) && (hcount_in == 11'd0);
  // 10-bit add: the carry is dropped so the image wraps horizontally
  assign col       = hcount_in[9:0] + x_off_q;

  always_comb begin
    rom_addr_d = vis ? {vcount_in[9:0], col} : 20'h0;
    rgb_d      = vld_pipe_q[1] ? rom_rgb : 12'h000;
    x_off_d    = x_off_q;
    // only stepped on the first blanking clock, so active video never tears
    if (frame_evt && scroll_en)
      x_off_d = x_off_q + {6'b0, scroll_step};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tim_s1_q   <= '0;
      tim_s2_q   <= '0;
      tim_s3_q   <= '0;
      vld_pipe_q <= '0;
      rom_addr_q <= '0;
      rgb_q      <= '0;
      x_off_q    <= '0;
    end else begin
      tim_s1_q   <= tim_in;
      tim_s2_q   <= tim_s1_q;
      tim_s3_q   <= tim_s2_q;
      vld_pipe_q <= {vld_pipe_q[0], vis};
      rom_addr_q <= rom_addr_d;
      rgb_q      <= rgb_d;
      x_off_q    <= x_off_d;
    end
  end

  assign rom_addr   = rom_addr_q;
  assign rgb_out    = rgb_q;
  assign x_off      = x_off_q;
  assign hcount_out = tim_s3_q.h;
  assign vcount_out = tim_s3_q.v;
  assign hsync_out  = tim_s3_q.hs;
  assign vsync_out  = tim_s3_q.vs;
  assign hblnk_out  = tim_s3_q.hb;
  assign vblnk_out  = tim_s3_q.vb;

endmodule

// File: tb/tb_bg_rom_reader.sv
// Directed bench for bg_rom_reader: sparse timing points, synchronous ROM model,
// queue scoreboard for rom_addr/x_off (+1 clk) and timing/rgb (+3 clk).
module tb_bg_rom_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic        scroll_en;
  logic [3:0]  scroll_step;
  logic [19:0] rom_addr;
  logic [11:0] rom_rgb;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;
  logic [9:0]  x_off;

  bg_rom_reader dut (
    .clk(clk), .rst_n(rst_n),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
    .scroll_en(scroll_en), .scroll_step(scroll_step),
    .rom_addr(rom_addr), .rom_rgb(rom_rgb),
    .hcount_out(hcount_out), .vcount_out(vcount_out),
    .hsync_out(hsync_out), .vsync_out(vsync_out), .hblnk_out(hblnk_out), .vblnk_out(vblnk_out),
    .rgb_out(rgb_out), .x_off(x_off)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [11:0] rom_fn(input logic [19:0] a);
    return a[11:0] ^ {a[19:12], a[3:0]} ^ 12'h5a3;
  endfunction

  always @(posedge clk) rom_rgb <= rom_fn(rom_addr);

  typedef struct {
    int          due;
    logic [19:0] addr;
    logic [9:0]  xo;
  } a_t;
  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic [10:0] h, v;
    logic        hs, vs, hb, vb;
  } o_t;

  a_t aq[$];
  o_t oq[$];
  logic [9:0] mx;
  logic       tb_en;
  logic [3:0] tb_step;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    a_t ea;
    o_t eo;
    while (aq.size() > 0 && aq[0].due <= cyc) begin
      ea = aq.pop_front();
      chk("addr_due", 32'(ea.due), 32'(cyc));
      chk("rom_addr", 32'(rom_addr), 32'(ea.addr));
      chk("x_off", 32'(x_off), 32'(ea.xo));
    end
    while (oq.size() > 0 && oq[0].due <= cyc) begin
      eo = oq.pop_front();
      chk("out_due", 32'(eo.due), 32'(cyc));
      chk("rgb_out", 32'(rgb_out), 32'(eo.rgb));
      chk("hcount_out", 32'(hcount_out), 32'(eo.h));
      chk("vcount_out", 32'(vcount_out), 32'(eo.v));
      chk("sync_blank_out", 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}),
          32'({eo.hs, eo.vs, eo.hb, eo.vb}));
    end
  end

  task automatic drive(input logic [10:0] h, input logic [10:0] v,
                       input logic hb = 1'b0, input logic vb = 1'b0,
                       input logic hs = 1'b0, input logic vs = 1'b0);
    a_t   ea;
    o_t   eo;
    logic vis;
    logic [9:0] col;
    @(negedge clk);
    hcount_in = h; vcount_in = v; hblnk_in = hb; vblnk_in = vb;
    hsync_in = hs; vsync_in = vs; scroll_en = tb_en; scroll_step = tb_step;
    vis     = !hb && !vb && (h < 11'd1024) && (v < 11'd768);
    col     = h[9:0] + mx;
    ea.due  = cyc + 1;
    ea.addr = vis ? {v[9:0], col} : 20'h0;
    if (v == 11'd768 && h == 11'd0 && tb_en) mx = mx + {6'b0, tb_step};
    ea.xo   = mx;
    aq.push_back(ea);
    eo.due = cyc + 3;
    eo.rgb = vis ? rom_fn(ea.addr) : 12'h000;
    eo.h = h; eo.v = v; eo.hs = hs; eo.vs = vs; eo.hb = hb; eo.vb = vb;
    oq.push_back(eo);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_addr"}, 32'(rom_addr), 32'd0);
    chk({tag, "_rgb"}, 32'(rgb_out), 32'd0);
    chk({tag, "_hv"}, 32'({hcount_out, vcount_out}), 32'd0);
    chk({tag, "_strobes"}, 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'd0);
    chk({tag, "_xoff"}, 32'(x_off), 32'd0);
  endtask

  task automatic frame_evt();
    drive(11'd0, 11'd768, 1'b1, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; mx = '0; tb_en = 1'b0; tb_step = 4'd0;
    // random inputs while held in reset
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      hcount_in = 11'($urandom); vcount_in = 11'($urandom);
      {hsync_in, vsync_in, hblnk_in, vblnk_in} = 4'($urandom);
      scroll_en = 1'b1; scroll_step = 4'($urandom);
    end
    @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    drive(11'd0, 11'd0);
    drive(11'd5, 11'd2);
    @(negedge clk);
    chk("addr_5_2", 32'(rom_addr), 32'h00805);
    drive(11'd1100, 11'd2, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(11'd1023, 11'd767);
    drive(11'd1023, 11'd768);
    drive(11'd10, 11'd3, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++)
      drive(11'($urandom_range(0, 1023)), 11'($urandom_range(0, 767)));

    // three scrolled frames: 4, 8, 12
    tb_en = 1'b1; tb_step = 4'd4;
    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 6; i++)
        drive(11'($urandom_range(0, 1023)), 11'($urandom_range(0, 767)));
      drive(11'd1030, 11'd767, 1'b1, 1'b0, 1'b1, 1'b0);
      frame_evt();
      drive(11'd1, 11'd768, 1'b0, 1'b1);
    end

    // walk the offset to 1020, then check the column wrap
    tb_step = 4'd8;
    for (int i = 0; i < 126; i++) frame_evt();
    drive(11'd10, 11'd100);
    @(negedge clk);
    chk("wrap_addr", 32'(rom_addr), 32'h19006);
    chk("wrap_xoff", 32'(x_off), 32'd1020);

    // hold cases: disabled, mid-frame toggle, zero step, non-event clock
    tb_en = 1'b0;
    frame_evt();
    drive(11'd7, 11'd8);
    frame_evt();
    tb_en = 1'b1;
    drive(11'd20, 11'd30);
    tb_en = 1'b0;
    drive(11'd21, 11'd30);
    frame_evt();
    tb_en = 1'b1; tb_step = 4'd0;
    frame_evt();
    tb_step = 4'd4;
    drive(11'd1, 11'd768, 1'b1, 1'b1);
    drive(11'd500, 11'd400);
    frame_evt();
    drive(11'd500, 11'd400);

    // asynchronous reset in the middle of a frame
    drive(11'd300, 11'd200);
    drive(11'd301, 11'd200);
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    aq.delete(); oq.delete(); mx = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    tb_step = 4'd9;
    drive(11'd302, 11'd200);
    drive(11'd303, 11'd200);
    frame_evt();
    drive(11'd4, 11'd5);
    repeat (4) drive(11'($urandom_range(0, 1023)), 11'($urandom_range(0, 767)));

    repeat (5) @(negedge clk);
    chk("drain", 32'(aq.size() + oq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bg_rom_reader.md
# bg_rom_reader

Pixel-fetch front end for the full-screen background image ROM. Takes the VGA timing stream (1024×768 active), generates the ROM read address for every pixel, absorbs the ROM's one-cycle read latency, and emits timing plus background RGB aligned at the output. Provides per-frame horizontal scrolling with wrap-around for a moving background. Sits between the VGA timing generator and the first sprite/overlay drawing stage.

## Interface
- H_ACTIVE, 1024, active pixels per line; power of two, column index is 10 bits
- V_ACTIVE, 768, active lines per frame
- clk  in  1  pixel clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- hcount_in  in  11  horizontal counter from timing stage
- vcount_in  in  11  vertical counter from timing stage
- hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each  timing strobes
- scroll_en  in  1  enables per-frame offset update
- scroll_step  in  4  pixels added to offset per frame
- rom_addr  out  20  ROM read address = {row[9:0], col[9:0]}
- rom_rgb  in  12  ROM data; valid one clk after rom_addr
- hcount_out, vcount_out  out  11 each  inputs delayed 3 clk
- hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each  inputs delayed 3 clk
- rgb_out  out  12  background pixel, aligned with *_out timing
- x_off  out  10  current scroll offset (debug/visibility)

## Operation
- Visible pixel: vis = !hblnk_in && !vblnk_in && hcount_in < H_ACTIVE && vcount_in < V_ACTIVE.
- Column: col = (hcount_in[9:0] + x_off) mod 1024; 10-bit add, carry discarded (wrap).
- Stage 1 (clk 1): rom_addr <= vis ? {vcount_in[9:0], col} : 20'h0; timing captured into stage-1 regs; vis captured.
- Stage 2 (clk 2): ROM returns rom_rgb; timing and vis shifted to stage-2 regs.
- Stage 3 (clk 3): rgb_out <= vis_s2 ? rom_rgb : 12'h000; timing regs driven to *_out.
- Address never exceeds 786431; blanked/out-of-range pixels read address 0, output black.
- Offset update: frame-update event = vcount_in == V_ACTIVE && hcount_in == 0 (first clk of vertical blank). On that clk, if scroll_en, x_off <= x_off + scroll_step (mod 1024); otherwise hold.
- x_off constant throughout active video: no tearing. Change of scroll_en/scroll_step during a frame has no effect until the next event.
- Offset update and stage-1 address computation on the same clk: address uses old x_off (pixel is blanked anyway).

## Timing
- Reset (rst_n low, asynchronous): rom_addr, rgb_out, hcount_out, vcount_out, all sync/blank outputs, all pipeline regs, x_off = 0.
- Reset mid-frame: outputs go 0 immediately; after release, *_out valid after 3 rising edges; x_off restarts from 0; the next frame-update event steps it normally.
- Latency: inputs sampled at edge N -> rom_addr at edge N+1 -> rgb_out and *_out at edge N+3. Fixed, no stalls, no handshake; one pixel per clk.
- All *_out and rgb_out change only on rising clk edges (registered).

## Test plan
- Reset: hold rst_n=0 with random inputs -> all outputs 0, x_off=0; release, drive hcount=0/vcount=0 non-blank -> rom_addr=0x00000 after 1 clk.
- Address/latency: x_off=0, hcount_in=5, vcount_in=2, blanks low -> rom_addr=0x00805 at edge+1; rgb_out equals ROM model word 0x00805 and hcount_out=5, vcount_out=2 at edge+3.
- Blanking: hblnk_in=1 at hcount=1100 -> rom_addr=0, rgb_out=12'h000 at edge+3, hblnk_out=1 aligned.
- Scroll update: scroll_en=1, scroll_step=4, run 3 full frames -> x_off 4, 8, 12, each changing only at vcount=768,hcount=0; x_off constant across every active region.
- Wrap: step x_off to 1020, hcount_in=10, vcount_in=100 -> rom_addr={10'd100,10'd6}=0x19006.
- Hold: scroll_en=0 (or step=0) over 2 frames -> x_off unchanged; toggling scroll_en mid-frame does not alter x_off before the next update event.
